// File: rtl/input_limit_sequencer.sv
// Stimulus sequencer: drives a 64-bit test vector pattern onto a DUT, waits a settle time,
// captures the 8-bit DUT result into a 16-bit MISR signature, and repeats for N vectors.
module input_limit_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [63:0] LFSR_SEED     = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] num_vectors,
    output logic [31:0] dut_in,
    output logic [31:0] dut_in2,
    input  logic [3:0]  dut_out,
    input  logic [3:0]  dut_out2,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [15:0] vec_count,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] num_q, num_d;
    logic [63:0] vec_q, vec_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  settle_q, settle_d;
    logic [7:0]  sample;

    function automatic logic [63:0] first_vec(input logic [1:0] m);
        case (m)
            2'b00:   first_vec = 64'h1;
            2'b01:   first_vec = 64'h0;
            2'b10:   first_vec = LFSR_SEED;
            default: first_vec = 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] next_vec(input logic [1:0] m, input logic [63:0] v);
        case (m)
            2'b00:   next_vec = {v[62:0], v[63]};
            2'b01:   next_vec = v + 64'h1;
            2'b10:   next_vec = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
            default: next_vec = ~v;
        endcase
    endfunction

    assign sample = {dut_out2, dut_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            num_q    <= 16'h0;
            vec_q    <= 64'h0;
            sig_q    <= 16'h0;
            cnt_q    <= 16'h0;
            settle_q <= 8'h0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            vec_q    <= vec_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        num_d    = num_q;
        vec_d    = vec_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    num_d    = num_vectors;
                    vec_d    = first_vec(mode);
                    sig_d    = 16'h0;
                    cnt_d    = 16'h0;
                    settle_d = 8'h0;
                    state_d  = (num_vectors == 16'h0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 8'h0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + 8'h1;
                end
            end
            CAPTURE: begin
                sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]}
                        ^ {8'h00, sample};
                cnt_d = cnt_q + 16'h1;
                // The last captured vector stays on the bus after the run.
                if (cnt_d == num_q) begin
                    state_d = DONE;
                end else begin
                    vec_d   = next_vec(mode_q, vec_q);
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_in    = vec_q[31:0];
    assign dut_in2   = vec_q[63:32];
    assign busy      = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign vec_count = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_input_limit_sequencer.sv
// Bench for input_limit_sequencer: a fake DUT derives the 8-bit result from the applied vector,
// a pattern model predicts every capture and run end, and a monitor scores them as they appear.
module tb_input_limit_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] num_vectors = 16'h0;
    logic [31:0] dut_in, dut_in2;
    logic [3:0]  dut_out, dut_out2;
    logic        busy, done;
    logic [15:0] signature, vec_count;
    logic [1:0]  state_o;

    logic [7:0]  key = 8'h0;
    logic        ovr_en = 1'b0;
    logic [7:0]  ovr_val = 8'h0;

    int unsigned cyc = 0;
    int passed = 0;
    int total = 0;

    typedef struct {
        int unsigned cyc;
        logic [63:0] vec;
        logic [15:0] sig;
        logic [15:0] cnt;
    } rec_t;

    rec_t cap_exp_q[$];
    rec_t done_exp_q[$];

    input_limit_sequencer #(.SETTLE_CYCLES(S), .LFSR_SEED(64'h1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vectors(num_vectors),
        .dut_in(dut_in), .dut_in2(dut_in2), .dut_out(dut_out), .dut_out2(dut_out2),
        .busy(busy), .done(done), .signature(signature), .vec_count(vec_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fake_dut(input logic [63:0] v, input logic [7:0] k,
                                            input logic oe, input logic [7:0] ov);
        if (oe) return ov;
        return v[7:0] ^ v[63:56] ^ v[35:28] ^ k;
    endfunction

    assign {dut_out2, dut_out} = fake_dut({dut_in2, dut_in}, key, ovr_en, ovr_val);

    function automatic logic [63:0] pat_first(input logic [1:0] m);
        if (m == 2'b00) return 64'h1;
        if (m == 2'b10) return 64'h1;
        return 64'h0;
    endfunction

    function automatic logic [63:0] pat_next(input logic [1:0] m, input logic [63:0] v);
        logic [63:0] r;
        case (m)
            2'b00: r = (v << 1) | (v >> 63);
            2'b01: r = v + 64'd1;
            2'b10: r = (v << 1) | 64'(v[63] ^ v[62] ^ v[60] ^ v[59]);
            default: r = (v == 64'h0) ? {64{1'b1}} : 64'h0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] g, input logic [7:0] s);
        logic fb;
        fb = g[15] ^ g[14] ^ g[12] ^ g[3];
        return ((g << 1) | 16'(fb)) ^ 16'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        total++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (rst_n) begin
            if (state_o == 2'd2) begin
                if (cap_exp_q.size() == 0) unexpected("capture");
                else begin
                    r = cap_exp_q.pop_front();
                    chk("cap_cycle", 64'(cyc), 64'(r.cyc));
                    chk("cap_vector", {dut_in2, dut_in}, r.vec);
                    chk("cap_sig_before", 64'(signature), 64'(r.sig));
                    chk("cap_count", 64'(vec_count), 64'(r.cnt));
                    chk("cap_busy", 64'(busy), 64'd1);
                end
            end
            if (done) begin
                if (done_exp_q.size() == 0) unexpected("done");
                else begin
                    r = done_exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(r.cyc));
                    chk("done_vector", {dut_in2, dut_in}, r.vec);
                    chk("done_signature", 64'(signature), 64'(r.sig));
                    chk("done_count", 64'(vec_count), 64'(r.cnt));
                    chk("done_busy", 64'(busy), 64'd0);
                end
            end
        end
    end

    // Issue one run, predict it, optionally poke start mid-run, and wait for its end.
    task automatic run(input logic [1:0] m, input int n, input logic oe, input logic [7:0] ov,
                       output logic [63:0] last_vec, output logic [15:0] last_sig);
        logic [63:0] v;
        logic [15:0] g;
        int unsigned t0;
        int lim, d, busy_seen;
        rec_t r;
        @(negedge clk);
        key = 8'($urandom);
        ovr_en = oe;
        ovr_val = ov;
        mode = m;
        num_vectors = 16'(n);
        start = 1'b1;
        t0 = cyc;
        v = pat_first(m);
        g = 16'h0;
        last_vec = v;
        for (int k = 0; k < n; k++) begin
            r.cyc = t0 + (k + 1) * (S + 1);
            r.vec = v;
            r.sig = g;
            r.cnt = 16'(k);
            cap_exp_q.push_back(r);
            g = misr(g, fake_dut(v, key, oe, ov));
            last_vec = v;
            v = pat_next(m, v);
        end
        r.cyc = t0 + 1 + n * (S + 1);
        r.vec = last_vec;
        r.sig = g;
        r.cnt = 16'(n);
        done_exp_q.push_back(r);
        last_sig = g;
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        if (n > 0) begin
            d = $urandom_range(1, (n * 3 < 4) ? n * 3 : 4);
            repeat (d - 1) @(negedge clk);
            mode = 2'($urandom);
            num_vectors = 16'($urandom_range(0, 9));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        lim = n * (S + 1) + 10;
        while (done_exp_q.size() != 0 && lim > 0) begin
            @(negedge clk);
            busy_seen |= busy;
            lim--;
        end
        if (done_exp_q.size() != 0) begin
            unexpected("run_timeout");
            cap_exp_q.delete();
            done_exp_q.delete();
        end
        if (n == 0) chk("empty_run_busy", 64'(busy_seen), 64'd0);
        @(negedge clk);
        chk("hold_vector", {dut_in2, dut_in}, last_vec);
        chk("hold_signature", 64'(signature), 64'(last_sig));
        chk("idle_busy", 64'(busy), 64'd0);
        ovr_en = 1'b0;
    endtask

    task automatic reset_mid_run(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        num_vectors = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dut_in", 64'(dut_in), 64'd0);
        chk("rst_dut_in2", 64'(dut_in2), 64'd0);
        chk("rst_signature", 64'(signature), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle_busy", 64'(busy), 64'd0);
        chk("post_rst_vector", {dut_in2, dut_in}, 64'd0);
    endtask

    initial begin
        logic [63:0] lv;
        logic [15:0] ls;
        #1;
        chk("reset_dut_in", {dut_in2, dut_in}, 64'd0);
        chk("reset_signature", 64'(signature), 64'd0);
        chk("reset_vec_count", 64'(vec_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(2'b00, 3, 1'b0, 8'h00, lv, ls);
        chk("walk3_last", lv, 64'h4);
        chk("walk3_count", 64'(vec_count), 64'd3);
        run(2'b01, 2, 1'b1, 8'h01, lv, ls);
        chk("cnt_sig_ones", 64'(signature), 64'h3);
        run(2'b01, 2, 1'b1, 8'h00, lv, ls);
        chk("cnt_sig_zeros", 64'(signature), 64'h0);
        run(2'b00, 0, 1'b0, 8'h00, lv, ls);
        chk("empty_sig", 64'(signature), 64'h0);
        chk("empty_count", 64'(vec_count), 64'h0);
        run(2'b00, 65, 1'b0, 8'h00, lv, ls);
        chk("walk65_last", {dut_in2, dut_in}, 64'h1);
        run(2'b10, 2, 1'b0, 8'h00, lv, ls);
        chk("lfsr2_last", {dut_in2, dut_in}, 64'h2);
        run(2'b11, 3, 1'b0, 8'h00, lv, ls);
        chk("alt3_last", {dut_in2, dut_in}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            run(2'($urandom), $urandom_range(0, 20), 1'b0, 8'h00, lv, ls);
        end

        reset_mid_run(2'b11);
        reset_mid_run(2'b10);
        run(2'b10, 5, 1'b0, 8'h00, lv, ls);

        chk("cap_queue_empty", 64'(cap_exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
